bp_be_wb_arbiter: RTL and testbench



---
 rtl/bp_be_wb_arbiter.sv | 114 +++++++++++
 tb/tb_bp_be_wb_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_wb_arbiter.sv
// bp_be_wb_arbiter: shares the regfile write port between commit writeback and
// buffered late writebacks, tracks registers awaiting a late write, and forces
// a one-cycle pipeline stall when the late head has lost the port too long.
// Optional feature macro: BP_BE_WB_ARB_BYPASS_EN (late input written directly
// when the buffer is empty and no commit write is present).
module bp_be_wb_arbiter #(
  parameter int unsigned dword_width_p    = 64,
  parameter int unsigned reg_addr_width_p = 5,
  parameter int unsigned late_fifo_els_p  = 2,
  parameter int unsigned starve_limit_p   = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        early_v_i,
  input  logic [reg_addr_width_p-1:0] early_addr_i,
  input  logic [dword_width_p-1:0]    early_data_i,
  input  logic                        late_v_i,
  input  logic [reg_addr_width_p-1:0] late_addr_i,
  input  logic [dword_width_p-1:0]    late_data_i,
  output logic                        late_ready_o,
  input  logic                        reserve_v_i,
  input  logic [reg_addr_width_p-1:0] reserve_addr_i,
  input  logic [reg_addr_width_p-1:0] rs1_addr_i,
  input  logic [reg_addr_width_p-1:0] rs2_addr_i,
  output logic                        rs1_pending_o,
  output logic                        rs2_pending_o,
  output logic                        stall_o,
  output logic                        rd_w_v_o,
  output logic [reg_addr_width_p-1:0] rd_addr_o,
  output logic [dword_width_p-1:0]    rd_data_o
);

  localparam int unsigned ptr_w_lp = $clog2(late_fifo_els_p);
  localparam int unsigned cnt_w_lp = $clog2(starve_limit_p + 1);
  localparam int unsigned regs_lp  = 1 << reg_addr_width_p;

  typedef struct packed {
    logic [reg_addr_width_p-1:0] addr;
    logic [dword_width_p-1:0]    data;
  } wb_entry_s;

  wb_entry_s                   mem_q [late_fifo_els_p];
  logic [ptr_w_lp:0]           rptr_q, wptr_q;
  logic [cnt_w_lp-1:0]         cnt_q, cnt_d, cnt_inc;
  logic                        stall_q, stall_d;
  logic [regs_lp-1:0]          pend_q, pend_d;

  logic                        empty, full, bypass, enq, deq, late_wr;
  wb_entry_s                   head, late_sel, late_in;

  assign empty   = (rptr_q == wptr_q);
  assign full    = (rptr_q[ptr_w_lp] != wptr_q[ptr_w_lp])
                && (rptr_q[ptr_w_lp-1:0] == wptr_q[ptr_w_lp-1:0]);
  assign head    = mem_q[rptr_q[ptr_w_lp-1:0]];
  assign late_in = '{addr: late_addr_i, data: late_data_i};
  assign stall_o = stall_q;

  assign rs1_pending_o = pend_q[rs1_addr_i];
  assign rs2_pending_o = pend_q[rs2_addr_i];

  // Port selection, buffer handshake, starvation and scoreboard next state
  always_comb begin
    late_ready_o = ~full & ~reset_i;
`ifdef BP_BE_WB_ARB_BYPASS_EN
    bypass       = ~reset_i & empty & ~early_v_i & late_v_i;
`else
    bypass       = 1'b0;
`endif
    enq          = late_v_i & late_ready_o & ~bypass;
    deq          = ~reset_i & ~empty & ~early_v_i;
    late_wr      = deq | bypass;
    late_sel     = bypass ? late_in : head;

    rd_addr_o    = early_v_i ? early_addr_i : late_sel.addr;
    rd_data_o    = early_v_i ? early_data_i : late_sel.data;
    rd_w_v_o     = ~reset_i & ((early_v_i | late_wr) & (rd_addr_o != '0));

    stall_d      = 1'b0;
    cnt_d        = '0;
    cnt_inc      = cnt_q + cnt_w_lp'(1);
    if (~empty & ~deq) begin
      if (cnt_inc == cnt_w_lp'(starve_limit_p)) stall_d = 1'b1;
      else                                      cnt_d   = cnt_inc;
    end

    // A reserve landing on the same register as the late write wins
    pend_d = pend_q;
    if (late_wr) pend_d[late_sel.addr] = 1'b0;
    if (reserve_v_i && (reserve_addr_i != '0)) pend_d[reserve_addr_i] = 1'b1;
  end

  // Control state: pointers, starvation counter, stall, scoreboard
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      cnt_q   <= '0;
      stall_q <= 1'b0;
      pend_q  <= '0;
    end else begin
      if (deq) rptr_q <= rptr_q + (ptr_w_lp + 1)'(1);
      if (enq) wptr_q <= wptr_q + (ptr_w_lp + 1)'(1);
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      pend_q  <= pend_d;
    end
  end

  // Late-writeback payload storage
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q[ptr_w_lp-1:0]] <= late_in;
  end

endmodule

// File: tb/tb_bp_be_wb_arbiter.sv
// Bench for bp_be_wb_arbiter: directed vector table plus randomized traffic,
// both checked cycle by cycle against a queue-based reference model.
module tb_bp_be_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
`ifdef BP_BE_WB_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_i, early_v_i, late_v_i, reserve_v_i;
  logic [4:0]  early_addr_i, late_addr_i, reserve_addr_i, rs1_addr_i, rs2_addr_i;
  logic [63:0] early_data_i, late_data_i;
  logic        late_ready_o, rs1_pending_o, rs2_pending_o, stall_o, rd_w_v_o;
  logic [4:0]  rd_addr_o;
  logic [63:0] rd_data_o;

  always #5 clk = ~clk;

  bp_be_wb_arbiter dut (
    .clk_i(clk), .reset_i(reset_i),
    .early_v_i(early_v_i), .early_addr_i(early_addr_i), .early_data_i(early_data_i),
    .late_v_i(late_v_i), .late_addr_i(late_addr_i), .late_data_i(late_data_i),
    .late_ready_o(late_ready_o),
    .reserve_v_i(reserve_v_i), .reserve_addr_i(reserve_addr_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_pending_o(rs1_pending_o), .rs2_pending_o(rs2_pending_o),
    .stall_o(stall_o), .rd_w_v_o(rd_w_v_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o)
  );

  typedef struct {
    bit rst, ev; bit [4:0] ea; bit [63:0] ed;
    bit lv; bit [4:0] la; bit [63:0] ld;
    bit rv; bit [4:0] ra; bit [4:0] rs1;
    bit rdy, wv; bit [4:0] wa; bit [63:0] wd; bit st, p1;
  } vec_t;

  typedef struct { bit [4:0] a; bit [63:0] d; } ent_t;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  ent_t q_m[$];
  int   lose_m;
  bit   stall_m;
  bit   pend_m [32];

  // Values derived during the check phase, consumed by the update phase
  bit        m_rdy, m_byp, m_has_late;
  bit [4:0]  m_late_a;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit rst, bit ev, bit [4:0] ea, bit [63:0] ed,
                              bit lv, bit [4:0] la, bit [63:0] ld,
                              bit rv, bit [4:0] ra, bit [4:0] rs1,
                              bit rdy, bit wv, bit [4:0] wa, bit [63:0] wd,
                              bit st, bit p1);
    vec_t v;
    v.rst = rst; v.ev = ev; v.ea = ea; v.ed = ed; v.lv = lv; v.la = la; v.ld = ld;
    v.rv = rv; v.ra = ra; v.rs1 = rs1;
    v.rdy = rdy; v.wv = wv; v.wa = wa; v.wd = wd; v.st = st; v.p1 = p1;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    reset_i = v.rst; early_v_i = v.ev; early_addr_i = v.ea; early_data_i = v.ed;
    late_v_i = v.lv; late_addr_i = v.la; late_data_i = v.ld;
    reserve_v_i = v.rv; reserve_addr_i = v.ra;
    rs1_addr_i = v.rs1; rs2_addr_i = v.rs1 + 5'd1;
  endtask

  // Compare DUT outputs with the model for the current cycle's inputs
  task automatic model_check(input vec_t v);
    bit has_w; bit [4:0] wa; bit [63:0] wd; int n;
    n = q_m.size();
    if (v.rst) begin
      chk("rst_ready", late_ready_o, 0);
      chk("rst_wv", rd_w_v_o, 0);
      return;
    end
    m_rdy = (n < DEPTH);
    m_byp = BYP && (n == 0) && !v.ev && v.lv;
    m_has_late = !v.ev && (m_byp || n > 0);
    m_late_a = m_byp ? v.la : (n > 0 ? q_m[0].a : 5'd0);
    has_w = 1'b1;
    if (v.ev)          begin wa = v.ea;    wd = v.ed;    end
    else if (m_byp)    begin wa = v.la;    wd = v.ld;    end
    else if (n > 0)    begin wa = q_m[0].a; wd = q_m[0].d; end
    else               begin has_w = 1'b0; wa = 0; wd = 0; end
    chk("model_ready", late_ready_o, m_rdy);
    chk("model_wv", rd_w_v_o, has_w && wa != 0);
    if (has_w && wa != 0) begin
      chk("model_waddr", rd_addr_o, wa);
      chk("model_wdata", rd_data_o, wd);
    end
    chk("model_stall", stall_o, stall_m);
    chk("model_rs1p", rs1_pending_o, pend_m[v.rs1]);
    chk("model_rs2p", rs2_pending_o, pend_m[v.rs1 + 5'd1]);
    chk("early_during_stall", stall_o & v.ev, 0);
  endtask

  task automatic model_update(input vec_t v);
    bit drained;
    if (v.rst) begin
      q_m.delete(); lose_m = 0; stall_m = 0;
      foreach (pend_m[i]) pend_m[i] = 0;
      return;
    end
    drained = !v.ev && !m_byp && q_m.size() > 0;
    if (q_m.size() > 0 && !drained) begin
      lose_m++;
      stall_m = (lose_m == LIMIT);
      if (stall_m) lose_m = 0;
    end else begin
      lose_m = 0; stall_m = 0;
    end
    if (drained) void'(q_m.pop_front());
    if (v.lv && m_rdy && !m_byp) q_m.push_back('{a: v.la, d: v.ld});
    if (m_has_late) pend_m[m_late_a] = 0;
    if (v.rv && v.ra != 0) pend_m[v.ra] = 1;
  endtask

  task automatic cycle(input vec_t v, input bit tchk, input int idx);
    drive(v);
    @(negedge clk);
    model_check(v);
    if (tchk) begin
      chk($sformatf("row%0d_ready", idx), late_ready_o, v.rdy);
      chk($sformatf("row%0d_wv", idx), rd_w_v_o, v.wv);
      if (v.wv) begin
        chk($sformatf("row%0d_waddr", idx), rd_addr_o, v.wa);
        chk($sformatf("row%0d_wdata", idx), rd_data_o, v.wd);
      end
      chk($sformatf("row%0d_stall", idx), stall_o, v.st);
      chk($sformatf("row%0d_rs1p", idx), rs1_pending_o, v.p1);
    end
    model_update(v);
    @(posedge clk); #1;
  endtask

  vec_t tbl [26];
  vec_t rv_v;

  initial begin
    //             rst ev ea  ed    lv la  ld       rv ra  rs1  rdy wv wa  wd      st p1
    tbl[0]  = mk(1, 0, 0, 0,     0, 0,  0,       0, 0,  0,   0, 0, 0,  0,      0, 0);
    tbl[1]  = mk(0, 0, 0, 0,     0, 0,  0,       1, 5,  5,   1, 0, 0,  0,      0, 0);
    if (BYP) begin
      tbl[2] = mk(0, 0, 0, 0,    1, 5,  'hDEAD,  0, 0,  5,   1, 1, 5,  'hDEAD, 0, 1);
      tbl[3] = mk(0, 0, 0, 0,    0, 0,  0,       0, 0,  5,   1, 0, 0,  0,      0, 0);
    end else begin
      tbl[2] = mk(0, 0, 0, 0,    1, 5,  'hDEAD,  0, 0,  5,   1, 0, 0,  0,      0, 1);
      tbl[3] = mk(0, 0, 0, 0,    0, 0,  0,       0, 0,  5,   1, 1, 5,  'hDEAD, 0, 1);
    end
    tbl[4]  = mk(0, 0, 0, 0,     0, 0,  0,       0, 0,  5,   1, 0, 0,  0,      0, 0);
    tbl[5]  = mk(0, 0, 0, 0,     0, 0,  0,       1, 7,  7,   1, 0, 0,  0,      0, 0);
    if (BYP) begin
      tbl[6] = mk(0, 0, 0, 0,    1, 7,  'h77,    0, 0,  7,   1, 1, 7,  'h77,   0, 1);
      tbl[7] = mk(0, 0, 0, 0,    0, 0,  0,       1, 7,  7,   1, 0, 0,  0,      0, 0);
    end else begin
      tbl[6] = mk(0, 0, 0, 0,    1, 7,  'h77,    0, 0,  7,   1, 0, 0,  0,      0, 1);
      tbl[7] = mk(0, 0, 0, 0,    0, 0,  0,       1, 7,  7,   1, 1, 7,  'h77,   0, 1);
    end
    tbl[8]  = mk(0, 0, 0, 0,     0, 0,  0,       0, 0,  7,   1, 0, 0,  0,      0, 1);
    tbl[9]  = mk(0, 1, 1, 'h11,  1, 3,  1,       0, 0,  3,   1, 1, 1,  'h11,   0, 0);
    tbl[10] = mk(0, 1, 1, 'h12,  1, 9,  'h99,    0, 0,  3,   1, 1, 1,  'h12,   0, 0);
    tbl[11] = mk(0, 1, 1, 'h13,  1, 10, 'hAA,    0, 0,  3,   0, 1, 1,  'h13,   0, 0);
    tbl[12] = mk(0, 1, 1, 'h14,  1, 10, 'hAA,    0, 0,  3,   0, 1, 1,  'h14,   0, 0);
    tbl[13] = mk(0, 1, 1, 'h15,  1, 10, 'hAA,    0, 0,  3,   0, 1, 1,  'h15,   0, 0);
    tbl[14] = mk(0, 0, 0, 0,     1, 10, 'hAA,    0, 0,  3,   0, 1, 3,  1,      1, 0);
    tbl[15] = mk(0, 0, 0, 0,     1, 10, 'hAA,    0, 0,  3,   1, 1, 9,  'h99,   0, 0);
    tbl[16] = mk(0, 0, 0, 0,     0, 0,  0,       0, 0,  3,   1, 1, 10, 'hAA,   0, 0);
    tbl[17] = mk(0, 0, 0, 0,     1, 0,  'h55,    1, 0,  0,   1, 0, 0,  0,      0, 0);
    tbl[18] = mk(0, 0, 0, 0,     0, 0,  0,       0, 0,  0,   1, 0, 0,  0,      0, 0);
    tbl[19] = mk(0, 0, 0, 0,     0, 0,  0,       0, 0,  0,   1, 0, 0,  0,      0, 0);
    tbl[20] = mk(0, 1, 2, 2,     1, 12, 'hC,     1, 12, 12,  1, 1, 2,  2,      0, 0);
    tbl[21] = mk(0, 1, 2, 2,     1, 13, 'hD,     1, 13, 12,  1, 1, 2,  2,      0, 1);
    tbl[22] = mk(0, 1, 2, 2,     0, 0,  0,       1, 14, 13,  0, 1, 2,  2,      0, 1);
    tbl[23] = mk(1, 0, 0, 0,     0, 0,  0,       0, 0,  14,  0, 0, 0,  0,      0, 1);
    tbl[24] = mk(0, 0, 0, 0,     0, 0,  0,       0, 0,  14,  1, 0, 0,  0,      0, 0);
    tbl[25] = mk(0, 0, 0, 0,     0, 0,  0,       0, 0,  12,  1, 0, 0,  0,      0, 0);

    // Initial reset so the directed table starts from a known state
    rv_v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(rv_v);
    @(posedge clk); #1;
    cycle(rv_v, 1'b0, -1);

    for (int i = 0; i < 26; i++) cycle(tbl[i], 1'b1, i);

    // Randomized traffic, early writes suppressed whenever a stall is due
    for (int i = 0; i < 600; i++) begin
      rv_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rv_v.rst = ($urandom_range(0, 79) == 0);
      rv_v.ev  = ($urandom_range(0, 2) != 0) && !stall_m;
      rv_v.ea  = 5'($urandom_range(0, 7));
      rv_v.ed  = {$urandom, $urandom};
      rv_v.lv  = $urandom_range(0, 1) != 0;
      rv_v.la  = 5'($urandom_range(0, 7));
      rv_v.ld  = {$urandom, $urandom};
      rv_v.rv  = $urandom_range(0, 2) == 0;
      rv_v.ra  = 5'($urandom_range(0, 7));
      rv_v.rs1 = 5'($urandom_range(0, 7));
      cycle(rv_v, 1'b0, i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
